eth_rx_store_forward: RTL and testbench
=======================================

Name: eth_rx_store_forward

Overview:
- Store-and-forward packet buffer on the MAC receive path, directly upstream of the kernel's MAC transmit stream (mac0_m / mac1_m).
- Accepts an AXI4-Stream packet from the MAC receive stream and never backpressures it.
- Releases a packet downstream only after its tlast beat is stored, so the transmit side never underruns mid-packet.
- Drops any packet that cannot fit and counts the drops.

Parameters:
C_TDATA_WIDTH, 512, stream data width in bits (multiple of 8)
C_DEPTH, 64, buffer depth in beats; power of 2, minimum 4
C_PTR_W, $clog2(C_DEPTH)+1, pointer width including the wrap bit (derived)

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous, active-low
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready; constant 1 outside reset
s_axis_tdata  in  C_TDATA_WIDTH  input data
s_axis_tkeep  in  C_TDATA_WIDTH/8  input byte enables
s_axis_tlast  in  1  input end of packet
m_axis_tvalid  out  1  output beat valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  C_TDATA_WIDTH  output data
m_axis_tkeep  out  C_TDATA_WIDTH/8  output byte enables
m_axis_tlast  out  1  output end of packet
stat_fill  out  C_PTR_W  beats currently stored, counting uncommitted beats
stat_drop_pulse  out  1  one-cycle pulse per dropped packet
stat_drop_count  out  32  dropped-packet count; wraps at 2^32

Behaviour:
- Clock and reset: single clock ap_clk. Reset ap_rst_n is asynchronous and active-low; deassertion is synchronous to ap_clk.
- Reset values: all pointers 0, write FSM in WR_ACCEPT, m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, s_axis_tready=0 while ap_rst_n is low, stat_fill=0, stat_drop_pulse=0, stat_drop_count=0.
- Storage: C_DEPTH entries, each holding {tlast, tkeep, tdata}.
- Pointers, all C_PTR_W bits wide:
  - wr_ptr: tentative write pointer.
  - commit_ptr: packet boundary pointer.
  - rd_ptr: read pointer.
- full = (wr_ptr - rd_ptr) == C_DEPTH, evaluated on registered values at the start of the cycle. A read in the same cycle does not clear full for that cycle.
- Write FSM:
  - WR_ACCEPT, beat accepted and not full: store the beat and increment wr_ptr. If tlast=1, set commit_ptr to wr_ptr+1 on the same edge.
  - WR_ACCEPT, beat accepted and full: discard the beat and set wr_ptr to commit_ptr on that edge.
    - If tlast=1: pulse stat_drop_pulse next cycle, increment stat_drop_count, stay in WR_ACCEPT.
    - If tlast=0: go to WR_DROP.
  - WR_DROP: discard every beat. On a tlast beat, pulse stat_drop_pulse, increment stat_drop_count, return to WR_ACCEPT.
- Oversize packets: a packet longer than C_DEPTH beats always reaches full and is dropped. A packet of exactly C_DEPTH beats into an empty buffer is accepted.
- Read side:
  - A beat is readable when rd_ptr != commit_ptr. Uncommitted beats are never visible downstream.
  - Output is a registered stage, first-word-fall-through. The output register refills on the same edge it is consumed when the next committed beat exists, so sustained throughput is 1 beat/cycle with m_axis_tready=1.
  - Latency: tlast accepted on edge k into an empty buffer with an idle output gives m_axis_tvalid=1 after edge k+2, presenting the first beat of that packet.
- AXI rules on the output:
  - m_axis_tvalid never deasserts without a handshake.
  - tdata/tkeep/tlast stay stable while tvalid=1 and tready=0.
  - tkeep and tlast pass through unmodified; no beat is reordered, duplicated or merged.
- stat_fill = wr_ptr - rd_ptr, registered. It drops back on rewind.
- Reset mid-operation: all buffered and partial packets are lost and outputs drop immediately. After reset there is no resynchronisation: a packet tail arriving first is stored as a packet.
- Simultaneous events: a write and a read in the same cycle are both honoured. A rewind and a read in the same cycle are both honoured; rd_ptr is never moved by a rewind.

Test Plan:
1. Empty buffer, m_axis_tready=1, one 4-beat packet (tdata = beat index; last tkeep=64'h0000_0000_0000_FFFF) -> m_axis_tvalid rises 2 edges after the tlast handshake; 4 identical beats out, tlast on beat 4 only, tkeep matches.
2. C_DEPTH=16, m_axis_tready=0, send a 10-beat then a 10-beat packet -> first packet kept, second dropped; stat_drop_count=1, one stat_drop_pulse, stat_fill=10. Set tready=1 -> exactly 10 beats out.
3. Exactly 16-beat packet into empty C_DEPTH=16 buffer with tready=0 -> accepted, stat_fill=16. Next 1-beat packet (tlast) -> dropped, count=1.
4. 20-beat packet, C_DEPTH=16, tready=1 from start -> no output beats, drop_count=1, stat_fill returns to 0. Following 3-beat packet passes intact.
5. Back-to-back 2-beat packets with m_axis_tready toggling every cycle -> all data in order, output stable while stalled, no beat lost or duplicated.
6. ap_rst_n pulled low asynchronously mid-packet and mid-readout -> m_axis_tvalid=0 and stat_fill=0 without a clock edge, drop_count=0. After release, a 3-beat packet passes with latency 2.

Source files
------------

// File: rtl/eth_rx_store_forward.sv
`default_nettype none
// eth_rx_store_forward: store-and-forward receive buffer that releases a packet only
// once its tlast beat is stored, dropping and counting packets that do not fit.
module eth_rx_store_forward #(
  parameter int C_TDATA_WIDTH = 512,
  parameter int C_DEPTH       = 64,
  parameter int C_PTR_W       = $clog2(C_DEPTH) + 1
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [C_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                       s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [C_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [C_PTR_W-1:0]         stat_fill,
  output logic                       stat_drop_pulse,
  output logic [31:0]                stat_drop_count
);

  localparam int C_KEEP_W  = C_TDATA_WIDTH / 8;
  localparam int C_ENTRY_W = C_TDATA_WIDTH + C_KEEP_W + 1;
  localparam int C_ADDR_W  = C_PTR_W - 1;

  typedef enum logic [0:0] {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_t;

  logic [C_ENTRY_W-1:0] mem [C_DEPTH];

  wr_state_t            wr_state, wr_state_nxt;
  logic [C_PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [C_PTR_W-1:0]   commit_ptr, commit_nxt;
  logic [C_PTR_W-1:0]   commit_vis;
  logic [C_PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
  logic                 full, store, drop_done;
  logic                 out_valid, handshake, load;
  logic [C_ENTRY_W-1:0] out_beat;

  assign s_axis_tready = ap_rst_n;
  assign full = (wr_ptr - rd_ptr) == C_PTR_W'(C_DEPTH);

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    commit_nxt   = commit_ptr;
    wr_state_nxt = wr_state;
    store        = 1'b0;
    drop_done    = 1'b0;
    if (s_axis_tvalid) begin
      case (wr_state)
        WR_ACCEPT: begin
          if (!full) begin
            store      = 1'b1;
            wr_ptr_nxt = wr_ptr + C_PTR_W'(1);
            if (s_axis_tlast) commit_nxt = wr_ptr + C_PTR_W'(1);
          end else begin
            // Rewind discards the partial packet; committed data stays intact.
            wr_ptr_nxt = commit_ptr;
            if (s_axis_tlast) drop_done = 1'b1;
            else              wr_state_nxt = WR_DROP;
          end
        end
        WR_DROP: begin
          if (s_axis_tlast) begin
            drop_done    = 1'b1;
            wr_state_nxt = WR_ACCEPT;
          end
        end
        default: wr_state_nxt = WR_ACCEPT;
      endcase
    end
  end

  // The output register always holds mem[rd_ptr]; rd_ptr moves on the downstream handshake.
  always_comb begin
    handshake  = out_valid && m_axis_tready;
    rd_ptr_nxt = handshake ? rd_ptr + C_PTR_W'(1) : rd_ptr;
    load       = (!out_valid || handshake) && (rd_ptr_nxt != commit_vis);
  end

  always_ff @(posedge ap_clk) begin
    if (store) mem[wr_ptr[C_ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_state        <= WR_ACCEPT;
      wr_ptr          <= '0;
      commit_ptr      <= '0;
      commit_vis      <= '0;
      rd_ptr          <= '0;
      out_valid       <= 1'b0;
      out_beat        <= '0;
      stat_fill       <= '0;
      stat_drop_pulse <= 1'b0;
      stat_drop_count <= '0;
    end else begin
      wr_state        <= wr_state_nxt;
      wr_ptr          <= wr_ptr_nxt;
      commit_ptr      <= commit_nxt;
      commit_vis      <= commit_ptr;
      rd_ptr          <= rd_ptr_nxt;
      stat_fill       <= wr_ptr_nxt - rd_ptr_nxt;
      stat_drop_pulse <= drop_done;
      if (drop_done) stat_drop_count <= stat_drop_count + 32'd1;
      if (load) begin
        out_valid <= 1'b1;
        out_beat  <= mem[rd_ptr_nxt[C_ADDR_W-1:0]];
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_beat[C_ENTRY_W-1];
  assign m_axis_tkeep  = out_beat[C_TDATA_WIDTH +: C_KEEP_W];
  assign m_axis_tdata  = out_beat[C_TDATA_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_store_forward.sv
`default_nettype none
// tb_eth_rx_store_forward: directed packets with a queue-based scoreboard; a monitor
// pops expected beats on every output handshake and checks stall stability.
module tb_eth_rx_store_forward;
  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  typedef logic [DW+KW:0] beat_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic [PW-1:0] stat_fill;
  logic          stat_drop_pulse;
  logic [31:0]   stat_drop_count;

  eth_rx_store_forward #(.C_TDATA_WIDTH(DW), .C_DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .stat_fill(stat_fill), .stat_drop_pulse(stat_drop_pulse), .stat_drop_count(stat_drop_count)
  );

  always #5 ap_clk = ~ap_clk;

  beat_t exp_q[$];
  int    total = 0;
  int    passed = 0;
  int    pulse_cnt = 0;
  int    exp_drops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  function automatic beat_t mk(input int base, input int i, input int n, input logic [KW-1:0] klast);
    beat_t b;
    b = '0;
    b[31:0] = base + i;
    b[DW +: KW] = (i == n - 1) ? klast : {KW{1'b1}};
    b[DW+KW] = (i == n - 1);
    return b;
  endfunction

  task automatic send(input int n, input int base, input logic [KW-1:0] klast,
                      input bit pass, input bit with_last = 1'b1);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b = mk(base, i, n, klast);
      if (!with_last) b[DW+KW] = 1'b0;
      if (pass) exp_q.push_back(b);
      {s_axis_tlast, s_axis_tkeep, s_axis_tdata} = b;
      s_axis_tvalid = 1'b1;
      @(posedge ap_clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge ap_clk); #1; end
  endtask

  // Called just after the tlast edge k: valid must appear only after edge k+2.
  task automatic latency_check(input string nm);
    check({nm, "_lat_k"}, 64'(m_axis_tvalid), 64'd0);
    cycles(1);
    check({nm, "_lat_k1"}, 64'(m_axis_tvalid), 64'd0);
    cycles(1);
    check({nm, "_lat_k2"}, 64'(m_axis_tvalid), 64'd1);
  endtask

  task automatic drain(input string nm);
    int guard;
    guard = 0;
    m_axis_tready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && guard < 300) begin
      cycles(1);
      guard++;
    end
    check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stats(input string nm, input int fill);
    check({nm, "_fill"}, 64'(stat_fill), 64'(fill));
    check({nm, "_drop_count"}, 64'(stat_drop_count), 64'(exp_drops));
    check({nm, "_drop_pulses"}, 64'(pulse_cnt), 64'(exp_drops));
  endtask

  // Monitor: scoreboard pop on handshake, stability while stalled, drop-pulse tally.
  beat_t held;
  bit    stalled = 1'b0;
  initial begin
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        stalled = 1'b0;
      end else begin
        beat_t cur;
        cur = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
        if (stalled) begin
          total++;
          if (m_axis_tvalid && cur === held) passed++;
          else $display("FAIL stall_stable: actual valid=%0b beat=%h required valid=1 beat=%h",
                        m_axis_tvalid, cur[DW+KW:DW], held[DW+KW:DW]);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_beat: actual data=%h required no beat", m_axis_tdata[63:0]);
          end else begin
            beat_t e;
            e = exp_q.pop_front();
            if (cur === e) passed++;
            else $display("FAIL out_beat: actual last=%0b keep=%h data=%h required last=%0b keep=%h data=%h",
                          cur[DW+KW], cur[DW +: KW], cur[63:0], e[DW+KW], e[DW +: KW], e[63:0]);
          end
        end
        if (stat_drop_pulse) pulse_cnt++;
        stalled = m_axis_tvalid && !m_axis_tready;
        held    = cur;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 ap_rst_n = 1'b0;
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_tdata", m_axis_tdata[63:0], 64'd0);
    stats("rst", 0);
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1 ap_rst_n = 1'b1;
    cycles(1);
    check("tready_up", 64'(s_axis_tready), 64'd1);

    // 1: single 4-beat packet, latency and pass-through
    m_axis_tready = 1'b1;
    send(4, 0, 64'h0000_0000_0000_FFFF, 1'b1);
    latency_check("t1");
    drain("t1");

    // 2: second 10-beat packet does not fit behind the first
    m_axis_tready = 1'b0;
    send(10, 100, {KW{1'b1}}, 1'b1);
    send(10, 200, {KW{1'b1}}, 1'b0);
    exp_drops = 1;
    cycles(2);
    stats("t2", 10);
    drain("t2");

    // 3: exactly DEPTH beats fit; a following single beat is dropped
    m_axis_tready = 1'b0;
    send(16, 300, 64'h0000_0000_0000_00FF, 1'b1);
    cycles(2);
    check("t3_fill_full", 64'(stat_fill), 64'd16);
    send(1, 350, 64'h0000_0000_0000_0001, 1'b0);
    exp_drops = 2;
    cycles(2);
    stats("t3", 16);
    drain("t3");

    // 4: oversize packet never appears; the next one passes
    m_axis_tready = 1'b1;
    send(20, 400, {KW{1'b1}}, 1'b0);
    exp_drops = 3;
    cycles(2);
    stats("t4", 0);
    send(3, 450, 64'h0000_0000_0000_0F0F, 1'b1);
    drain("t4");

    // 5: back-to-back 2-beat packets with toggling tready
    m_axis_tready = 1'b0;
    fork
      begin
        for (int p = 0; p < 6; p++) send(2, 500 + 10 * p, 64'h0000_0000_0000_00FF, 1'b1);
      end
      begin
        repeat (40) begin @(posedge ap_clk); #1 m_axis_tready = ~m_axis_tready; end
      end
    join
    drain("t5");

    // 6: asynchronous reset mid-packet and mid-readout
    m_axis_tready = 1'b0;
    send(6, 600, {KW{1'b1}}, 1'b1);
    cycles(2);
    m_axis_tready = 1'b1;
    send(2, 700, {KW{1'b1}}, 1'b0, 1'b0);
    ap_rst_n = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    pulse_cnt = 0;
    #1;
    check("t6_async_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_async_tready", 64'(s_axis_tready), 64'd0);
    stats("t6_async", 0);
    cycles(2);
    ap_rst_n = 1'b1;
    cycles(1);
    send(3, 800, 64'h0000_0000_0000_3FFF, 1'b1);
    latency_check("t6");
    drain("t6");
    stats("t6_end", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
